// File: rtl/wrr_burst_sched_pkg.sv
// rtl/wrr_burst_sched_pkg.sv - shared types and helpers for the weighted round-robin burst scheduler
package wrr_burst_sched_pkg;

  localparam int NUM_REQ        = 4;
  localparam int WEIGHT_WIDTH   = 4;
  localparam int DEFAULT_WEIGHT = 1;
  localparam int IDX_W          = $clog2(NUM_REQ);

  typedef logic [IDX_W-1:0]        idx_t;
  typedef logic [WEIGHT_WIDTH-1:0] weight_t;

  // A programmed weight of zero still grants one beat per burst.
  function automatic weight_t eff_weight(weight_t w);
    return (w == '0) ? weight_t'(1) : w;
  endfunction

endpackage

// File: rtl/wrr_sched_pick.sv
// rtl/wrr_sched_pick.sv - combinational rotate-priority picker: first set req at or after ptr, with wrap
module wrr_sched_pick #(
  parameter int NumReq = 4,
  parameter int IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   ptr,
  output logic [IdxW-1:0]   idx,
  output logic              any
);

  logic [IdxW-1:0] cand [NumReq];

  for (genvar k = 0; k < NumReq; k++) begin : g_cand
    assign cand[k] = IdxW'((int'(ptr) + k) % NumReq);
  end

  // Walk from the farthest candidate back to ptr so the nearest one wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        idx = cand[k];
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wrr_burst_sched.sv
// rtl/wrr_burst_sched.sv - weighted round-robin scheduler holding the grant for weighted bursts
// Optional stall counter output enabled by WRR_BURST_SCHED_STATS_EN.
module wrr_burst_sched
  import wrr_burst_sched_pkg::*;
#(
  parameter int NumReq        = NUM_REQ,
  parameter int WeightWidth   = WEIGHT_WIDTH,
  parameter int DefaultWeight = DEFAULT_WEIGHT
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic [NumReq-1:0]          req_i,
  output logic [NumReq-1:0]          gnt_o,
  output logic                       vld_o,
  input  logic                       ready_i,
  output logic [$clog2(NumReq)-1:0]  idx_o,
`ifdef WRR_BURST_SCHED_STATS_EN
  output logic [15:0]                stall_cnt_o,
`endif
  input  logic                       cfg_we_i,
  input  logic [$clog2(NumReq)-1:0]  cfg_idx_i,
  input  logic [WeightWidth-1:0]     cfg_weight_i
);

  localparam int IdxW = $clog2(NumReq);

  logic [IdxW-1:0]        ptr_q, lidx_q, pick_idx, win_idx, win_next;
  logic [WeightWidth-1:0] cnt_q, start_cnt;
  logic [WeightWidth-1:0] weight_q [NumReq];
  logic                   lock_q, pick_any, win_vld, hs, burst_mid, owner_drop;

  wrr_sched_pick #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_pick (
    .req (req_i),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  // lidx_q doubles as the burst owner: it follows the presented winner every valid cycle.
  always_comb begin
    burst_mid  = (cnt_q != '0);
    owner_drop = burst_mid && !lock_q && !req_i[lidx_q];
    win_idx    = pick_idx;
    win_vld    = pick_any;
    if (lock_q) begin
      win_idx = lidx_q;
      win_vld = 1'b1;
    end else if (burst_mid) begin
      win_idx = lidx_q;
      win_vld = req_i[lidx_q];
    end
  end

  assign win_next  = (win_idx == IdxW'(NumReq - 1)) ? '0 : win_idx + IdxW'(1);
  assign start_cnt = eff_weight(weight_q[win_idx]) - WeightWidth'(1);
  assign hs        = win_vld && ready_i;

  assign vld_o = rst_ni && win_vld;
  assign idx_o = rst_ni ? win_idx : '0;
  assign gnt_o = (vld_o && ready_i) ? (NumReq'(1) << idx_o) : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q  <= '0;
      cnt_q  <= '0;
      lock_q <= 1'b0;
      lidx_q <= '0;
      for (int i = 0; i < NumReq; i++) weight_q[i] <= WeightWidth'(DefaultWeight);
    end else begin
      if (cfg_we_i && (int'(cfg_idx_i) < NumReq)) weight_q[cfg_idx_i] <= cfg_weight_i;
      if (flush_i) begin
        ptr_q  <= '0;
        cnt_q  <= '0;
        lock_q <= 1'b0;
        lidx_q <= '0;
      end else if (hs) begin
        lock_q <= 1'b0;
        lidx_q <= win_idx;
        if (!burst_mid) begin
          cnt_q <= start_cnt;
          if (start_cnt == '0) ptr_q <= win_next;
        end else begin
          cnt_q <= cnt_q - WeightWidth'(1);
          if (cnt_q == WeightWidth'(1)) ptr_q <= win_next;
        end
      end else if (win_vld) begin
        lock_q <= 1'b1;
        lidx_q <= win_idx;
      end else if (owner_drop) begin
        ptr_q <= win_next;
        cnt_q <= '0;
      end
    end
  end

`ifdef WRR_BURST_SCHED_STATS_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else if (flush_i) begin
      stall_cnt_q <= '0;
    end else if (win_vld && !ready_i && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

  // A locked requester must hold its request until the beat is accepted.
  lock_hold_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (lock_q && !flush_i) |-> req_i[lidx_q]);

endmodule

// File: tb/tb_wrr_burst_sched.sv
// tb/tb_wrr_burst_sched.sv - directed self-checking bench for wrr_burst_sched
module tb_wrr_burst_sched;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       flush_i = 1'b0;
  logic [3:0] req_i = '0;
  logic [3:0] gnt_o;
  logic       vld_o;
  logic       ready_i = 1'b0;
  logic [1:0] idx_o;
  logic       cfg_we_i = 1'b0;
  logic [1:0] cfg_idx_i = '0;
  logic [3:0] cfg_weight_i = '0;
`ifdef WRR_BURST_SCHED_STATS_EN
  logic [15:0] stall_cnt_o;
`endif

  int total = 0;
  int bad = 0;

  wrr_burst_sched dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (flush_i),
    .req_i        (req_i),
    .gnt_o        (gnt_o),
    .vld_o        (vld_o),
    .ready_i      (ready_i),
    .idx_o        (idx_o),
`ifdef WRR_BURST_SCHED_STATS_EN
    .stall_cnt_o  (stall_cnt_o),
`endif
    .cfg_we_i     (cfg_we_i),
    .cfg_idx_i    (cfg_idx_i),
    .cfg_weight_i (cfg_weight_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic write_weight(input int i, input int w);
    cfg_we_i = 1'b1;
    cfg_idx_i = 2'(i);
    cfg_weight_i = 4'(w);
    cyc();
    cfg_we_i = 1'b0;
  endtask

  task automatic do_flush();
    req_i = '0;
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    req_i = '0;
    repeat (2) cyc();
    total++;
    if (vld_o !== 1'b0 || gnt_o !== 4'b0000 || idx_o !== 2'd0) begin
      bad++;
      $display("FAIL reset_idle vld=%b gnt=%b idx=%0d want 0 0000 0", vld_o, gnt_o, idx_o);
    end
    req_i = 4'b1111;
    ready_i = 1'b1;
    #1;
    total++;
    if (vld_o !== 1'b0 || gnt_o !== 4'b0000) begin
      bad++;
      $display("FAIL reset_req vld=%b gnt=%b want 0 0000", vld_o, gnt_o);
    end
    req_i = '0;
    rst_ni = 1'b1;
    cyc();
  endtask

  task automatic test_equal_weights();
    int exp_seq[5];
    exp_seq = '{0, 1, 2, 3, 0};
    req_i = 4'b1111;
    ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++;
      if (vld_o !== 1'b1 || idx_o !== 2'(exp_seq[k]) || gnt_o !== (4'b0001 << exp_seq[k])) begin
        bad++;
        $display("FAIL equal_rr step %0d vld=%b idx=%0d gnt=%b want 1 %0d %b",
                 k, vld_o, idx_o, gnt_o, exp_seq[k], 4'b0001 << exp_seq[k]);
      end
      cyc();
    end
    do_flush();
  endtask

  task automatic test_weights();
    int exp_seq[8];
    exp_seq = '{0, 0, 0, 1, 2, 2, 3, 0};
    write_weight(0, 3);
    write_weight(1, 1);
    write_weight(2, 2);
    write_weight(3, 1);
    do_flush();
    req_i = 4'b1111;
    ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      total++;
      if (idx_o !== 2'(exp_seq[k]) || gnt_o !== (4'b0001 << exp_seq[k])) begin
        bad++;
        $display("FAIL weighted step %0d idx=%0d gnt=%b want %0d", k, idx_o, gnt_o, exp_seq[k]);
      end
      cyc();
    end
    do_flush();
  endtask

  task automatic test_stall();
    write_weight(2, 1);
    do_flush();
    req_i = 4'b0100;
    ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++;
      if (vld_o !== 1'b1 || idx_o !== 2'd2 || gnt_o !== 4'b0000) begin
        bad++;
        $display("FAIL stall_hold cyc %0d vld=%b idx=%0d gnt=%b want 1 2 0000", k, vld_o, idx_o, gnt_o);
      end
      cyc();
    end
    req_i = 4'b0101;
    ready_i = 1'b1;
    #1;
    total++;
    if (vld_o !== 1'b1 || idx_o !== 2'd2 || gnt_o !== 4'b0100) begin
      bad++;
      $display("FAIL stall_release vld=%b idx=%0d gnt=%b want 1 2 0100", vld_o, idx_o, gnt_o);
    end
`ifdef WRR_BURST_SCHED_STATS_EN
    total++;
    if (stall_cnt_o !== 16'd5) begin
      bad++;
      $display("FAIL stall_cnt got %0d want 5", stall_cnt_o);
    end
`endif
    cyc();
    #1;
    total++;
    if (idx_o !== 2'd0 || gnt_o !== 4'b0001) begin
      bad++;
      $display("FAIL stall_wrap idx=%0d gnt=%b want 0 0001", idx_o, gnt_o);
    end
    do_flush();
`ifdef WRR_BURST_SCHED_STATS_EN
    total++;
    if (stall_cnt_o !== 16'd0) begin
      bad++;
      $display("FAIL stall_cnt_flush got %0d want 0", stall_cnt_o);
    end
`endif
  endtask

  task automatic test_owner_drop();
    write_weight(1, 4);
    do_flush();
    req_i = 4'b0010;
    ready_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      total++;
      if (idx_o !== 2'd1 || gnt_o !== 4'b0010) begin
        bad++;
        $display("FAIL drop_beat %0d idx=%0d gnt=%b want 1 0010", k, idx_o, gnt_o);
      end
      cyc();
    end
    req_i = 4'b1101;
    #1;
    total++;
    if (vld_o !== 1'b0 || gnt_o !== 4'b0000) begin
      bad++;
      $display("FAIL drop_cycle vld=%b gnt=%b want 0 0000", vld_o, gnt_o);
    end
    cyc();
    total++;
    if (vld_o !== 1'b1 || idx_o !== 2'd2 || gnt_o !== 4'b0100) begin
      bad++;
      $display("FAIL drop_resume vld=%b idx=%0d gnt=%b want 1 2 0100", vld_o, idx_o, gnt_o);
    end
    cyc();
    total++;
    if (idx_o !== 2'd3) begin
      bad++;
      $display("FAIL drop_next idx=%0d want 3", idx_o);
    end
    do_flush();
  endtask

  task automatic test_weight_race();
    int exp_seq[5];
    exp_seq = '{0, 1, 0, 0, 1};
    write_weight(0, 1);
    write_weight(1, 1);
    do_flush();
    req_i = 4'b0011;
    ready_i = 1'b1;
    cfg_we_i = 1'b1;
    cfg_idx_i = 2'd0;
    cfg_weight_i = 4'd2;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++;
      if (idx_o !== 2'(exp_seq[k]) || gnt_o !== (4'b0001 << exp_seq[k])) begin
        bad++;
        $display("FAIL race step %0d idx=%0d gnt=%b want %0d", k, idx_o, gnt_o, exp_seq[k]);
      end
      cyc();
      cfg_we_i = 1'b0;
    end
    do_flush();
  endtask

  task automatic test_flush_and_reset();
    write_weight(2, 3);
    do_flush();
    req_i = 4'b0100;
    ready_i = 1'b1;
    #1;
    total++;
    if (idx_o !== 2'd2) begin
      bad++;
      $display("FAIL flush_first idx=%0d want 2", idx_o);
    end
    cyc();
    req_i = 4'b1111;
    flush_i = 1'b1;
    #1;
    total++;
    if (vld_o !== 1'b1 || idx_o !== 2'd2) begin
      bad++;
      $display("FAIL flush_mid vld=%b idx=%0d want 1 2", vld_o, idx_o);
    end
    cyc();
    flush_i = 1'b0;
    #1;
    total++;
    if (idx_o !== 2'd0 || gnt_o !== 4'b0001) begin
      bad++;
      $display("FAIL flush_after idx=%0d gnt=%b want 0 0001", idx_o, gnt_o);
    end
    cyc();
    total++;
    if (idx_o !== 2'd0) begin
      bad++;
      $display("FAIL burst_before_reset idx=%0d want 0", idx_o);
    end
    rst_ni = 1'b0;
    #1;
    total++;
    if (vld_o !== 1'b0 || gnt_o !== 4'b0000 || idx_o !== 2'd0) begin
      bad++;
      $display("FAIL async_reset vld=%b gnt=%b idx=%0d want 0 0000 0", vld_o, gnt_o, idx_o);
    end
    cyc();
    rst_ni = 1'b1;
    #1;
    total++;
    if (idx_o !== 2'd0 || gnt_o !== 4'b0001) begin
      bad++;
      $display("FAIL post_reset idx=%0d gnt=%b want 0 0001", idx_o, gnt_o);
    end
    cyc();
    total++;
    if (idx_o !== 2'd1) begin
      bad++;
      $display("FAIL post_reset_weight idx=%0d want 1", idx_o);
    end
    req_i = '0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_equal_weights();
    test_weights();
    test_stall();
    test_owner_drop();
    test_weight_race();
    test_flush_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
